interrupt_cont_pri: RTL and testbench

Parametrised interrupt controller, successor to the 16-bit mask/status controller on the VEXpro peripheral bus.
- Supports 1..16 channels, each selectable as level or rising-edge triggered.
- Pending bits are sticky in edge mode and cleared by write-1-to-clear.
- Software can trigger any channel.
- Provides a priority-encoded vector register and a registered CPU interrupt line.

---
 rtl/interrupt_cont_pri.sv | 144 ++++++++++++++
 tb/tb_interrupt_cont_pri.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_cont_pri.sv
// interrupt_cont_pri: parametrised interrupt controller with per-channel level/edge
// triggering, sticky edge pending bits, software trigger, a fixed-priority vector
// register and a registered CPU interrupt line.
//
// Build option: define INTC_SYNC_EN to insert a two-flop synchronizer ahead of the
// input sample stage for sources asynchronous to Clk.
//
// Ports:
//   Clk        system clock, rising edge
//   ResetN     synchronous reset, active-low
//   Addr       register select (0 MASK, 1 PEND, 2 MODE, 3 RAW, 4 VEC, 5..7 reserved)
//   DataRd     read data, combinational from Addr and register state
//   DataWr     write data
//   En         block select
//   Rd         read strobe; reads have no side effects
//   Wr         write strobe; a write happens when Wr & En
//   IntStatus  raw interrupt sources
//   IntReset   one-cycle acknowledge pulse per channel after a PEND write
//   Int        registered interrupt request to the CPU
module interrupt_cont_pri #(
    parameter int unsigned NCH = 16
) (
    input  logic           Clk,
    input  logic           ResetN,
    input  logic [2:0]     Addr,
    output logic [15:0]    DataRd,
    input  logic [15:0]    DataWr,
    input  logic           En,
    input  logic           Rd,
    input  logic           Wr,
    input  logic [NCH-1:0] IntStatus,
    output logic [NCH-1:0] IntReset,
    output logic           Int
);

    localparam logic [2:0] AddrMask = 3'd0;
    localparam logic [2:0] AddrPend = 3'd1;
    localparam logic [2:0] AddrMode = 3'd2;
    localparam logic [2:0] AddrRaw  = 3'd3;
    localparam logic [2:0] AddrVec  = 3'd4;

    logic [NCH-1:0] srcIn;
    logic [NCH-1:0] sampleQ, samplePrevQ;
    logic [NCH-1:0] maskQ, maskD;
    logic [NCH-1:0] modeQ, modeD;
    logic [NCH-1:0] pendQ, pendD;
    logic [NCH-1:0] intResetQ;
    logic           intQ;

    logic           wrStrobe;
    logic [NCH-1:0] clr, swSet, edgeDet, active;
    logic [15:0]    maskW, pendW, modeW, rawW, vecW;
    logic [3:0]     vecIdx;

    // Reads are non-destructive, so the strobe carries no information here.
    logic unusedRd;
    assign unusedRd = Rd;

`ifdef INTC_SYNC_EN
    logic [NCH-1:0] sync1Q, sync2Q;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sync1Q <= '0;
            sync2Q <= '0;
        end else begin
            sync1Q <= IntStatus;
            sync2Q <= sync1Q;
        end
    end

    assign srcIn = sync2Q;
`else
    assign srcIn = IntStatus;
`endif

    always_comb begin
        wrStrobe = Wr & En;
        clr      = (wrStrobe && Addr == AddrPend) ? DataWr[NCH-1:0] : '0;
        swSet    = (wrStrobe && Addr == AddrRaw)  ? DataWr[NCH-1:0] : '0;
        maskD    = (wrStrobe && Addr == AddrMask) ? DataWr[NCH-1:0] : maskQ;
        modeD    = (wrStrobe && Addr == AddrMode) ? DataWr[NCH-1:0] : modeQ;
        edgeDet  = sampleQ & ~samplePrevQ;
        // Edge channels are sticky and any set source beats a clear; level channels
        // simply follow the sampled source, so a PEND clear has no effect on them.
        pendD    = (modeQ & ((pendQ & ~clr) | edgeDet | swSet)) |
                   (~modeQ & (sampleQ | swSet));
        active   = pendQ & maskQ;
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sampleQ     <= '0;
            samplePrevQ <= '0;
            maskQ       <= '0;
            modeQ       <= '0;
            pendQ       <= '0;
            intResetQ   <= '0;
            intQ        <= 1'b0;
        end else begin
            sampleQ     <= srcIn;
            samplePrevQ <= sampleQ;
            maskQ       <= maskD;
            modeQ       <= modeD;
            pendQ       <= pendD;
            intResetQ   <= clr;
            intQ        <= |active;
        end
    end

    assign IntReset = intResetQ;
    assign Int      = intQ;

    // Read path: widen channel vectors to the 16-bit bus, unused bits read 0.
    always_comb begin
        maskW            = '0;
        pendW            = '0;
        modeW            = '0;
        rawW             = '0;
        maskW[NCH-1:0]   = maskQ;
        pendW[NCH-1:0]   = active;
        modeW[NCH-1:0]   = modeQ;
        rawW[NCH-1:0]    = pendQ;

        // Scan downward so the lowest active index is the last one assigned.
        vecIdx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (active[i]) begin
                vecIdx = 4'(i);
            end
        end
        vecW = (|active) ? {1'b1, 11'd0, vecIdx} : 16'h0000;

        case (Addr)
            AddrMask: DataRd = maskW;
            AddrPend: DataRd = pendW;
            AddrMode: DataRd = modeW;
            AddrRaw:  DataRd = rawW;
            AddrVec:  DataRd = vecW;
            default:  DataRd = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_interrupt_cont_pri.sv
// Directed testbench for interrupt_cont_pri: a 16-channel instance and a 4-channel
// instance share the bus address/data/strobe lines but have separate block selects,
// resets and interrupt sources. Inputs change and outputs are sampled just after the
// falling edge.
module tb_interrupt_cont_pri;

    logic        Clk = 1'b0;
    logic        ResetN, ResetN4;
    logic [2:0]  Addr;
    logic [15:0] DataWr;
    logic        Wr, Rd, En, En4;
    logic [15:0] DataRd, DataRd4;
    logic [15:0] IntStatus, IntReset;
    logic [3:0]  IntStatus4, IntReset4;
    logic        Int, Int4;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    interrupt_cont_pri #(.NCH(16)) dut (
        .Clk(Clk), .ResetN(ResetN), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
        .En(En), .Rd(Rd), .Wr(Wr), .IntStatus(IntStatus), .IntReset(IntReset), .Int(Int)
    );

    interrupt_cont_pri #(.NCH(4)) dut4 (
        .Clk(Clk), .ResetN(ResetN4), .Addr(Addr), .DataRd(DataRd4), .DataWr(DataWr),
        .En(En4), .Rd(Rd), .Wr(Wr), .IntStatus(IntStatus4), .IntReset(IntReset4),
        .Int(Int4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rdChk(input bit sel4, input logic [2:0] a, input logic [15:0] exp,
                         input string tag);
        Addr = a;
        Rd   = 1'b1;
        #1;
        chk(tag, sel4 ? DataRd4 : DataRd, exp);
        Rd   = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input bit to16,
                      input bit to4);
        Addr   = a;
        DataWr = d;
        Wr     = 1'b1;
        En     = to16;
        En4    = to4;
        @(negedge Clk);
        Wr     = 1'b0;
        En     = 1'b0;
        En4    = 1'b0;
    endtask

    initial begin
        ResetN = 1'b0; ResetN4 = 1'b0;
        Addr = '0; DataWr = '0; Wr = 1'b0; Rd = 1'b0; En = 1'b0; En4 = 1'b0;
        IntStatus = '0; IntStatus4 = '0;
        repeat (2) @(negedge Clk);

        // Reset: a write during reset is dropped, every register reads 0.
        wr(3'd0, 16'hFFFF, 1'b1, 1'b1);
        ResetN = 1'b1; ResetN4 = 1'b1;
        @(negedge Clk);
        for (int a = 0; a < 8; a++) rdChk(1'b0, 3'(a), 16'h0000, "reset_read");
        chk("reset_int", 16'(Int), 16'h0000);
        chk("reset_intreset", IntReset, 16'h0000);
        rdChk(1'b1, 3'd0, 16'h0000, "reset_wr_ignored4");
        wr(3'd5, 16'hFFFF, 1'b1, 1'b0);
        rdChk(1'b0, 3'd5, 16'h0000, "reserved_addr5");

        // Edge channel 0: one-cycle pulse, Int at cycle 3, sticky, cleared by PEND.
        wr(3'd2, 16'h0001, 1'b1, 1'b0);
        wr(3'd0, 16'h0001, 1'b1, 1'b0);
        IntStatus = 16'h0001;
        @(negedge Clk);
        IntStatus = 16'h0000;
        chk("edge_lat_c1", 16'(Int), 16'h0000);
        @(negedge Clk);
        chk("edge_lat_c2", 16'(Int), 16'h0000);
        @(negedge Clk);
        chk("edge_lat_c3", 16'(Int), 16'h0001);
        repeat (2) @(negedge Clk);
        chk("edge_sticky", 16'(Int), 16'h0001);
        rdChk(1'b0, 3'd1, 16'h0001, "edge_pend");
        rdChk(1'b0, 3'd4, 16'h8000, "edge_vec0");
        wr(3'd1, 16'h0001, 1'b1, 1'b0);
        chk("ack_pulse", IntReset, 16'h0001);
        chk("int_after_clr_c0", 16'(Int), 16'h0001);
        @(negedge Clk);
        chk("int_after_clr_c1", 16'(Int), 16'h0000);
        chk("ack_pulse_end", IntReset, 16'h0000);
        rdChk(1'b0, 3'd3, 16'h0000, "edge_raw_cleared");
        wr(3'd2, 16'h0000, 1'b1, 1'b0);

        // Level channel 5: PEND clear acks but does not clear while the source holds.
        wr(3'd0, 16'h0020, 1'b1, 1'b0);
        IntStatus = 16'h0020;
        repeat (3) @(negedge Clk);
        chk("level_int", 16'(Int), 16'h0001);
        rdChk(1'b0, 3'd4, 16'h8005, "level_vec5");
        wr(3'd1, 16'h0020, 1'b1, 1'b0);
        chk("level_ack", IntReset, 16'h0020);
        rdChk(1'b0, 3'd3, 16'h0020, "level_raw_held");
        @(negedge Clk);
        chk("level_ack_end", IntReset, 16'h0000);
        chk("level_int_held", 16'(Int), 16'h0001);
        IntStatus = 16'h0000;
        repeat (2) @(negedge Clk);
        chk("level_drop_c2", 16'(Int), 16'h0001);
        @(negedge Clk);
        chk("level_drop_c3", 16'(Int), 16'h0000);
        wr(3'd0, 16'h0000, 1'b1, 1'b0);

        // Edge channels 3 and 9: fixed priority, unmask/mask timing.
        wr(3'd2, 16'hFFFF, 1'b1, 1'b0);
        IntStatus = 16'h0208;
        @(negedge Clk);
        IntStatus = 16'h0000;
        repeat (2) @(negedge Clk);
        rdChk(1'b0, 3'd3, 16'h0208, "prio_raw");
        rdChk(1'b0, 3'd1, 16'h0000, "prio_pend_masked");
        wr(3'd0, 16'h0208, 1'b1, 1'b0);
        chk("unmask_c0", 16'(Int), 16'h0000);
        @(negedge Clk);
        chk("unmask_c1", 16'(Int), 16'h0001);
        rdChk(1'b0, 3'd4, 16'h8003, "prio_vec3");
        wr(3'd1, 16'h0008, 1'b1, 1'b0);
        rdChk(1'b0, 3'd4, 16'h8009, "prio_vec9");
        wr(3'd0, 16'h0000, 1'b1, 1'b0);
        chk("mask_c0", 16'(Int), 16'h0001);
        @(negedge Clk);
        chk("mask_c1", 16'(Int), 16'h0000);
        rdChk(1'b0, 3'd3, 16'h0200, "mask_raw_kept");
        rdChk(1'b0, 3'd4, 16'h0000, "mask_vec_none");
        wr(3'd1, 16'h0200, 1'b1, 1'b0);
        rdChk(1'b0, 3'd3, 16'h0000, "prio_raw_cleared");

        // Edge channel 2: clear on the edge-detect cycle loses, then software trigger.
        IntStatus = 16'h0004;
        @(negedge Clk);
        wr(3'd1, 16'h0004, 1'b1, 1'b0);
        chk("set_beats_clr_ack", IntReset, 16'h0004);
        rdChk(1'b0, 3'd3, 16'h0004, "set_beats_clr");
        wr(3'd1, 16'h0004, 1'b1, 1'b0);
        rdChk(1'b0, 3'd3, 16'h0000, "clr_no_edge");
        IntStatus = 16'h0000;
        wr(3'd0, 16'h0004, 1'b1, 1'b0);
        wr(3'd3, 16'h0004, 1'b1, 1'b0);
        chk("swset_c0", 16'(Int), 16'h0000);
        @(negedge Clk);
        chk("swset_c1", 16'(Int), 16'h0001);
        rdChk(1'b0, 3'd4, 16'h8002, "swset_vec2");

        // NCH=4: upper bits ignored; source held high through reset is a new edge.
        wr(3'd0, 16'hFFFF, 1'b0, 1'b1);
        rdChk(1'b1, 3'd0, 16'h000F, "n4_mask");
        wr(3'd2, 16'hFFFF, 1'b0, 1'b1);
        rdChk(1'b1, 3'd2, 16'h000F, "n4_mode");
        IntStatus4 = 4'h2;
        repeat (3) @(negedge Clk);
        rdChk(1'b1, 3'd3, 16'h0002, "n4_raw_pre");
        ResetN4 = 1'b0;
        repeat (2) @(negedge Clk);
        rdChk(1'b1, 3'd3, 16'h0000, "n4_raw_in_reset");
        rdChk(1'b1, 3'd2, 16'h0000, "n4_mode_in_reset");
        chk("n4_int_in_reset", 16'(Int4), 16'h0000);
        ResetN4 = 1'b1;
        wr(3'd2, 16'h000F, 1'b0, 1'b1);
        rdChk(1'b1, 3'd3, 16'h0000, "n4_release_c1");
        @(negedge Clk);
        rdChk(1'b1, 3'd3, 16'h0002, "n4_release_c2");
        chk("n4_intreset", 16'(IntReset4), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
